// File: rtl/hdb_pkg.sv
// Shared symbol codes and pipeline slot type for the HDBn line encoder.
package hdb_pkg;

  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_ONE  = 2'b01;
  localparam logic [1:0] SYM_B    = 2'b10;
  localparam logic [1:0] SYM_V    = 2'b11;

  typedef struct packed {
    logic       valid;
    logic [1:0] code;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{valid: 1'b0, code: SYM_ZERO};

  // Only a real, unsubstituted zero may extend a run; empty, B and V slots break it.
  function automatic logic is_zero(slot_t s);
    return s.valid && (s.code == SYM_ZERO);
  endfunction

endpackage

// File: rtl/hdb_polarity.sv
// Output register for the encoder: maps an ejected slot to a tagged symbol and a bipolar pulse.
module hdb_polarity
  import hdb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  input  logic       ej_valid,
  input  logic [1:0] ej_code,
  output logic       out_valid,
  output logic [1:0] out_sym,
  output logic       out_p,
  output logic       out_n
);

  logic last_pos;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_sym   <= SYM_ZERO;
      out_p     <= 1'b0;
      out_n     <= 1'b0;
      last_pos  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_sym   <= SYM_ZERO;
      out_p     <= 1'b0;
      out_n     <= 1'b0;
      if (adv && ej_valid) begin
        out_valid <= 1'b1;
        out_sym   <= ej_code;
        case (ej_code)
          SYM_ONE, SYM_B: begin
            out_p    <= ~last_pos;
            out_n    <= last_pos;
            last_pos <= ~last_pos;
          end
          // V deliberately repeats the previous polarity: that is the violation.
          SYM_V: begin
            out_p <= last_pos;
            out_n <= ~last_pos;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/hdbn_encoder.sv
// HDBn line encoder: W-slot substitution pipeline feeding the polarity output stage.
module hdbn_encoder
  import hdb_pkg::*;
#(
  parameter int N_ZEROS = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_data,
  input  logic             ami_mode,
  input  logic             flush,
  output logic             out_valid,
  output logic [1:0]       out_sym,
  output logic             out_p,
  output logic             out_n,
  output logic [CNT_W-1:0] v_count
);

  localparam int W = N_ZEROS + 1;

  slot_t [W-1:0] slots;
  slot_t         new_slot;
  logic          adv;
  logic          run_zero;
  logic          sub;
  logic          parity;

  assign adv = in_valid | flush;

  always_comb begin
    run_zero = 1'b1;
    for (int i = 0; i < W - 1; i++) begin
      if (!is_zero(slots[i])) run_zero = 1'b0;
    end
  end

  always_comb begin
    new_slot = SLOT_EMPTY;
    sub      = 1'b0;
    if (in_valid) begin
      if (in_data) begin
        new_slot = '{valid: 1'b1, code: SYM_ONE};
      end else if (!ami_mode && run_zero) begin
        sub      = 1'b1;
        new_slot = '{valid: 1'b1, code: SYM_V};
      end else begin
        new_slot = '{valid: 1'b1, code: SYM_ZERO};
      end
    end
  end

  // The oldest zero of the run lands in s[W-1] on this same shift, so B goes there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slots  <= '{default: SLOT_EMPTY};
      parity <= 1'b0;
    end else if (adv) begin
      slots <= {slots[W-2:0], new_slot};
      if (sub && !parity) slots[W-1] <= '{valid: 1'b1, code: SYM_B};
      if (in_valid && in_data) parity <= ~parity;
      else if (sub)            parity <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_count <= '0;
    end else if (sub && !(&v_count)) begin
      v_count <= v_count + CNT_W'(1);
    end
  end

  hdb_polarity u_polarity (
    .clk      (clk),
    .rst      (rst),
    .adv      (adv),
    .ej_valid (slots[W-1].valid),
    .ej_code  (slots[W-1].code),
    .out_valid(out_valid),
    .out_sym  (out_sym),
    .out_p    (out_p),
    .out_n    (out_n)
  );

endmodule
